// File: rtl/lz_pkg.sv
// Shared constants and width helper for the leading-zero normalizer.
package lz_pkg;

  // Count width that can hold every value 0..n inclusive.
  function automatic int clog2p1(input int n);
    int w;
    w = 0;
    while ((1 << w) < (n + 1)) w++;
    return w;
  endfunction

  localparam int LZ_N  = 8;
  localparam int LZ_CW = clog2p1(LZ_N);

endpackage

// File: rtl/lz_priority_enc.sv
// Combinational leading-zero counter: MSB-first count, N for an all-zero word.
module lz_priority_enc
  import lz_pkg::*;
#(
  parameter int N = LZ_N,
  localparam int CW = clog2p1(N)
) (
  input  logic [N-1:0]  data,
  output logic [CW-1:0] lzc,
  output logic          zero
);

  // Scanning upward lets the highest set bit overwrite any lower hit.
  always_comb begin
    lzc = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (data[i]) lzc = CW'(N - 1 - i);
    end
  end

  assign zero = ~|data;

endmodule

// File: rtl/lz_normalize_pipe.sv
// Two-stage normalizer: S1 captures the word and its lzc, S2 holds the shifted result.
module lz_normalize_pipe
  import lz_pkg::*;
#(
  parameter int N = LZ_N,
  localparam int CW = clog2p1(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] out_lzc,
  output logic          out_zero
);

  localparam int SW = $clog2(N);

  logic          s1_valid;
  logic [N-1:0]  s1_data;
  logic [CW-1:0] s1_lzc;
  logic          s1_zero;
  logic          s2_valid;
  logic [N-1:0]  s2_data;
  logic [CW-1:0] s2_lzc;
  logic          s2_zero;
  logic          s1_en;
  logic          s2_en;
  logic [CW-1:0] enc_lzc;
  logic          enc_zero;
  logic [N-1:0]  lvl [0:SW];

  lz_priority_enc #(.N(N)) u_enc (
    .data (in_data),
    .lzc  (enc_lzc),
    .zero (enc_zero)
  );

  assign s2_en    = !s2_valid | out_ready;
  assign s1_en    = !s1_valid | s2_en;
  assign in_ready = s1_en;

  // Barrel shifter; an lzc of N only occurs for a zero word, so its low bits are harmless.
  assign lvl[0] = s1_data;
  for (genvar g = 0; g < SW; g++) begin : g_shift
    assign lvl[g+1] = s1_lzc[g] ? (lvl[g] << (2 ** g)) : lvl[g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_lzc   <= '0;
      s2_zero  <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_lzc  <= enc_lzc;
          s1_zero <= enc_zero;
        end
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= lvl[SW];
          s2_lzc  <= s1_lzc;
          s2_zero <= s1_zero;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_lzc   = s2_lzc;
  assign out_zero  = s2_zero;

endmodule
